// File: rtl/rom_rd_arbiter.sv
// rom_rd_arbiter: round-robin owner of the shared ROM read port.
// Each channel strobe buys one burst of WORDS timed reads at addresses 0..WORDS-1.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   strob     per-channel request strobes (asynchronous levels)
//   rd        one-hot read pulse to the granted channel
//   rd_adr    shared read address, 0 when idle
//   grant_id  index of the granted channel, valid while busy
//   busy      a burst is in progress
//   done      one-clock pulse on the channel whose burst just finished

module rom_rd_arbiter #(
    parameter int N_CH     = 5,
    parameter int WORDS    = 18,
    parameter int SLOT_LEN = 64,
    parameter int RD_START = 40,
    parameter int RD_LEN   = 4,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   strob,
    output logic [N_CH-1:0]   rd,
    output logic [ADDR_W-1:0] rd_adr,
    output logic [2:0]        grant_id,
    output logic              busy,
    output logic [N_CH-1:0]   done
);

    localparam int CNT_W = $clog2(SLOT_LEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SLOT = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0]  RD_FIRST  = CNT_W'(RD_START);
    localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(RD_START + RD_LEN - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(WORDS - 1);
    localparam logic [N_CH-1:0]   ONE       = N_CH'(1);
    localparam logic [2:0]        PTR_INIT  = 3'(N_CH - 1);

    logic [N_CH-1:0]   sync1_q, sync2_q, sync3_q;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]   rd_q, rd_d;
    logic [N_CH-1:0]   done_q, done_d;

    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   own_mask;
    logic              hi_found, lo_found;
    logic [2:0]        hi_pick, lo_pick, pick;

    function automatic logic [N_CH-1:0] ch_mask(input logic [2:0] id);
        return ONE << id;
    endfunction

    // Round-robin search: lowest pending index above rr_ptr, else lowest
    // pending index overall (the wrap-around). Descending loop so the
    // smallest qualifying index is written last.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lo_found = 1'b1;
                lo_pick  = 3'(i);
                if (3'(i) > rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_pick  = 3'(i);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        word_d     = word_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;

        rise = sync2_q & ~sync3_q;
        // The channel that owns the port cannot queue a second burst.
        own_mask  = (state_q != S_IDLE) ? ch_mask(grant_q) : '0;
        pending_d = pending_q | (rise & ~own_mask);

        unique case (state_q)
            S_IDLE: begin
                if (lo_found) begin
                    grant_d    = pick;
                    word_d     = '0;
                    slot_cnt_d = '0;
                    state_d    = S_SLOT;
                end
            end
            S_SLOT: begin
                if (slot_cnt_q == SLOT_LAST) begin
                    slot_cnt_d = '0;
                    if (word_q == WORD_LAST) begin
                        state_d = S_REL;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                end
            end
            S_REL: begin
                pending_d = pending_d & ~ch_mask(grant_q);
                rr_ptr_d  = grant_q;
                word_d    = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // rd/done are decoded from next state so the flops line up with state_q.
        rd_d = '0;
        if (state_d == S_SLOT && slot_cnt_d >= RD_FIRST &&
            slot_cnt_d <= RD_LAST) begin
            rd_d = ch_mask(grant_d);
        end
        done_d = (state_d == S_REL) ? ch_mask(grant_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            pending_q  <= '0;
            state_q    <= S_IDLE;
            slot_cnt_q <= '0;
            word_q     <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= PTR_INIT;
            rd_q       <= '0;
            done_q     <= '0;
        end else begin
            sync1_q    <= strob;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            pending_q  <= pending_d;
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            word_q     <= word_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_q       <= rd_d;
            done_q     <= done_d;
        end
    end

    assign rd       = rd_q;
    assign done     = done_q;
    assign rd_adr   = word_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// tb_rom_rd_arbiter: directed stimulus with an expected-grant scoreboard.
// A cycle monitor checks every burst against an independent slot-timing model.

module tb_rom_rd_arbiter;

    localparam int N_CH  = 5;
    localparam int WORDS = 18;
    localparam int SLOT  = 64;
    localparam int RDS   = 40;
    localparam int RDL   = 4;
    localparam int BLEN  = WORDS * SLOT;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] strob;
    logic [N_CH-1:0] rd;
    logic [4:0]      rd_adr;
    logic [2:0]      grant_id;
    logic            busy;
    logic [N_CH-1:0] done;

    rom_rd_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .strob    (strob),
        .rd       (rd),
        .rd_adr   (rd_adr),
        .grant_id (grant_id),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_q[$];
    int n_exp     = 0;
    int n_bursts  = 0;
    int gap_from  = 0;
    bit gap_mode  = 1'b0;
    int idle_err  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: samples 1ns after each rising edge.
    int         cyc, cur_ch, gap;
    int         rd_err, adr_err, done_err, busy_err, pulses;
    bit         in_burst  = 1'b0;
    bit         prev_busy = 1'b0;
    logic [N_CH-1:0] exp_rd, exp_done;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            in_burst  = 1'b0;
            prev_busy = 1'b0;
            gap       = 0;
        end else begin
            if (busy && !prev_busy) begin
                if (gap_mode && n_bursts >= gap_from)
                    chk("idle_gap", 32'(gap), 32'd1);
                n_bursts++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_burst", 32'(grant_id), 32'hffff_ffff);
                    cur_ch = int'(grant_id);
                end else begin
                    cur_ch = exp_q.pop_front();
                    chk("grant_order", 32'(grant_id), 32'(cur_ch));
                end
                cyc = 0; in_burst = 1'b1;
                rd_err = 0; adr_err = 0; done_err = 0;
                busy_err = 0; pulses = 0;
            end
            if (in_burst) begin
                exp_rd = '0;
                if (cyc < BLEN && (cyc % SLOT) >= RDS &&
                    (cyc % SLOT) < RDS + RDL)
                    exp_rd = N_CH'(1) << cur_ch;
                exp_done = (cyc == BLEN) ? (N_CH'(1) << cur_ch) : '0;
                if (rd !== exp_rd) rd_err++;
                if (cyc < BLEN && rd_adr !== 5'(cyc / SLOT)) adr_err++;
                if (done !== exp_done) done_err++;
                if (busy !== (cyc <= BLEN)) busy_err++;
                if (rd != 0) pulses++;
                if (cyc == BLEN + 1) begin
                    chk("burst_rd", 32'(rd_err), 32'd0);
                    chk("burst_adr", 32'(adr_err), 32'd0);
                    chk("burst_done", 32'(done_err), 32'd0);
                    chk("burst_busy", 32'(busy_err), 32'd0);
                    chk("rd_clks", 32'(pulses), 32'(WORDS * RDL));
                    in_burst = 1'b0;
                end
                cyc++;
            end else begin
                if (busy || rd !== '0 || done !== '0 || rd_adr !== '0)
                    idle_err++;
            end
            gap = busy ? 0 : gap + 1;
            prev_busy = busy;
        end
    end

    task automatic push(input int ch);
        exp_q.push_back(ch);
        n_exp++;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_clk);
        bit ok = 1'b0;
        for (int i = 0; i < max_clk; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !in_burst) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    int quiet;
    bit hit;

    initial begin
        rst   = 1'b1;
        strob = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_adr", 32'(rd_adr), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        rst = 1'b0;

        // T1 single burst on ch2 with latency check
        @(negedge clk) strob[2] = 1'b1;
        push(2);
        repeat (3) @(negedge clk);
        chk("t1_lat_k2", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_lat_k3", 32'(busy), 32'd1);
        chk("t1_grant", 32'(grant_id), 32'd2);
        repeat (5) @(negedge clk);
        strob = '0;
        wait_idle("t1_idle", BLEN + 100);
        chk("t1_count", 32'(n_bursts), 32'(n_exp));

        // T2 simultaneous ch0 and ch3
        do_reset();
        gap_from = n_bursts + 1;
        gap_mode = 1'b1;
        @(negedge clk) strob = 5'b01001;
        push(0);
        push(3);
        repeat (5) @(negedge clk);
        strob = '0;
        wait_idle("t2_idle", 2 * BLEN + 100);
        gap_mode = 1'b0;
        chk("t2_count", 32'(n_bursts), 32'(n_exp));

        // T3 fairness: ch4 first, then ch0 before ch1
        do_reset();
        @(negedge clk) strob[4] = 1'b1;
        push(4);
        repeat (100) @(negedge clk);
        strob[4] = 1'b0;
        strob[1] = 1'b1;
        repeat (5) @(negedge clk);
        strob[0] = 1'b1;
        push(0);
        push(1);
        repeat (5) @(negedge clk);
        strob = '0;
        wait_idle("t3_idle", 3 * BLEN + 200);
        chk("t3_count", 32'(n_bursts), 32'(n_exp));

        // T4 held strobe and re-strobe during own burst
        do_reset();
        @(negedge clk) strob[1] = 1'b1;
        push(1);
        repeat (3000) @(negedge clk);
        strob[1] = 1'b0;
        wait_idle("t4_held_idle", 200);
        chk("t4_held_count", 32'(n_bursts), 32'(n_exp));
        @(negedge clk) strob[1] = 1'b1;
        push(1);
        repeat (200) @(negedge clk);
        strob[1] = 1'b0;
        repeat (10) @(negedge clk);
        strob[1] = 1'b1;
        repeat (10) @(negedge clk);
        strob[1] = 1'b0;
        wait_idle("t4_re_idle", BLEN + 100);
        repeat (50) @(negedge clk);
        chk("t4_re_count", 32'(n_bursts), 32'(n_exp));
        chk("t4_re_busy", 32'(busy), 32'd0);

        // T5 reset mid-burst at word 7
        do_reset();
        @(negedge clk) strob[3] = 1'b1;
        push(3);
        repeat (5) @(negedge clk);
        strob[3] = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy && rd_adr == 5'd7) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t5_reach_w7", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rd", 32'(rd), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_adr", 32'(rd_adr), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        rst = 1'b0;
        quiet = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy || done !== '0) quiet++;
        end
        chk("t5_no_resume", 32'(quiet), 32'd0);
        chk("t5_count", 32'(n_bursts), 32'(n_exp));
        @(negedge clk) strob[3] = 1'b1;
        push(3);
        repeat (5) @(negedge clk);
        strob[3] = 1'b0;
        wait_idle("t5_idle", BLEN + 100);
        chk("t5_count2", 32'(n_bursts), 32'(n_exp));

        // T6 all five together
        do_reset();
        gap_from = n_bursts + 1;
        gap_mode = 1'b1;
        @(negedge clk) strob = 5'b11111;
        for (int c = 0; c < N_CH; c++) push(c);
        repeat (5) @(negedge clk);
        strob = '0;
        wait_idle("t6_idle", N_CH * (BLEN + 2) + 100);
        gap_mode = 1'b0;
        chk("t6_count", 32'(n_bursts), 32'(n_exp));

        chk("idle_outputs", 32'(idle_err), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
